// File: rtl/rocc_acc_pkg.sv
// Shared encodings for the RoCC accumulator unit: funct codes, FSM states, memory command.
package rocc_acc_pkg;

  localparam logic [6:0] FUNCT_WRITE = 7'd0;
  localparam logic [6:0] FUNCT_READ  = 7'd1;
  localparam logic [6:0] FUNCT_ACCUM = 7'd2;
  localparam logic [6:0] FUNCT_LOAD  = 7'd3;

  localparam logic [4:0] MEM_CMD_XRD = 5'b00000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_RESP
  } state_e;

  function automatic logic is_nop(input logic [6:0] funct);
    return funct > FUNCT_LOAD;
  endfunction

endpackage

// File: rtl/rocc_acc_regfile.sv
// Accumulator storage: NUM_ACC x XLEN, one combinational read port, one write port.
module rocc_acc_regfile #(
  parameter int XLEN    = 64,
  parameter int NUM_ACC = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_we,
  input  logic [$clog2(NUM_ACC)-1:0] i_waddr,
  input  logic [XLEN-1:0]            i_wdata,
  input  logic [$clog2(NUM_ACC)-1:0] i_raddr,
  output logic [XLEN-1:0]            o_rdata
);

  logic [XLEN-1:0] r_acc [NUM_ACC];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_ACC; k++) r_acc[k] <= '0;
    end else if (i_we) begin
      r_acc[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_acc[i_raddr];

endmodule

// File: rtl/rocc_acc_unit.sv
// RoCC accumulator: WRITE/READ/ACCUM/LOAD on NUM_ACC registers, single-beat memory loads
// with nack replay, response held until accepted.
module rocc_acc_unit
  import rocc_acc_pkg::*;
#(
  parameter int xLen             = 64,
  parameter int NUM_ACC          = 4,
  parameter int coreMaxAddrBits  = 40,
  parameter int dcacheReqTagBits = 9
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rocc_cmd_valid,
  output logic                        rocc_cmd_ready,
  input  logic [6:0]                  rocc_cmd_bits_inst_funct,
  input  logic [4:0]                  rocc_cmd_bits_inst_rd,
  input  logic                        rocc_cmd_bits_inst_xd,
  input  logic [xLen-1:0]             rocc_cmd_bits_rs1,
  input  logic [xLen-1:0]             rocc_cmd_bits_rs2,
  input  logic [1:0]                  rocc_cmd_bits_status_dprv,
  input  logic                        rocc_resp_ready,
  output logic                        rocc_resp_valid,
  output logic [4:0]                  rocc_resp_bits_rd,
  output logic [xLen-1:0]             rocc_resp_bits_data,
  input  logic                        rocc_mem_req_ready,
  output logic                        rocc_mem_req_valid,
  output logic [coreMaxAddrBits-1:0]  rocc_mem_req_bits_addr,
  output logic [dcacheReqTagBits-1:0] rocc_mem_req_bits_tag,
  output logic [4:0]                  rocc_mem_req_bits_cmd,
  output logic [1:0]                  rocc_mem_req_bits_size,
  output logic                        rocc_mem_req_bits_signed,
  output logic                        rocc_mem_req_bits_phys,
  output logic                        rocc_mem_req_bits_no_alloc,
  output logic                        rocc_mem_req_bits_no_xcpt,
  output logic                        rocc_mem_req_bits_no_resp,
  output logic                        rocc_mem_req_bits_dv,
  output logic [1:0]                  rocc_mem_req_bits_dprv,
  input  logic                        rocc_mem_s2_nack,
  input  logic                        rocc_mem_resp_valid,
  input  logic [xLen-1:0]             rocc_mem_resp_bits_data,
  output logic                        rocc_busy,
  output logic                        rocc_interrupt
);

  localparam int IDX_W = $clog2(NUM_ACC);

  state_e                     r_state, w_state_nxt;
  logic [6:0]                 r_funct;
  logic [4:0]                 r_rd;
  logic                       r_xd;
  logic [IDX_W-1:0]           r_idx;
  logic [coreMaxAddrBits-1:0] r_addr;
  logic [1:0]                 r_dprv;

  logic                       w_accept;
  logic [IDX_W-1:0]           w_idx;
  logic                       w_we;
  logic [xLen-1:0]            w_wdata;
  logic [xLen-1:0]            w_rdata;
  logic                       w_unused;

  assign w_unused = ^rocc_cmd_bits_rs2[xLen-1:IDX_W];
  assign w_accept = (r_state == S_IDLE) && rocc_cmd_valid;
  // In IDLE the index comes straight off the command so the op lands at T+1.
  assign w_idx    = (r_state == S_IDLE) ? rocc_cmd_bits_rs2[IDX_W-1:0] : r_idx;

  rocc_acc_regfile #(.XLEN(xLen), .NUM_ACC(NUM_ACC)) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (w_wdata),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_funct <= '0;
      r_rd    <= '0;
      r_xd    <= 1'b0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_dprv  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_funct <= rocc_cmd_bits_inst_funct;
        r_rd    <= rocc_cmd_bits_inst_rd;
        r_xd    <= rocc_cmd_bits_inst_xd;
        r_idx   <= rocc_cmd_bits_rs2[IDX_W-1:0];
        r_addr  <= rocc_cmd_bits_rs1[coreMaxAddrBits-1:0];
        r_dprv  <= rocc_cmd_bits_status_dprv;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_wdata     = w_rdata + rocc_cmd_bits_rs1;
    case (r_state)
      S_IDLE: begin
        if (rocc_cmd_valid) begin
          case (rocc_cmd_bits_inst_funct)
            FUNCT_WRITE: begin
              w_we    = 1'b1;
              w_wdata = rocc_cmd_bits_rs1;
            end
            FUNCT_ACCUM: w_we = 1'b1;
            default: ;
          endcase
          if (rocc_cmd_bits_inst_funct == FUNCT_LOAD) w_state_nxt = S_MEM_REQ;
          else if (rocc_cmd_bits_inst_xd)             w_state_nxt = S_RESP;
        end
      end
      S_MEM_REQ: if (rocc_mem_req_ready) w_state_nxt = S_MEM_WAIT;
      S_MEM_WAIT: begin
        // A nack wins over a same-cycle response: the load is replayed.
        if (rocc_mem_s2_nack) begin
          w_state_nxt = S_MEM_REQ;
        end else if (rocc_mem_resp_valid) begin
          w_we        = 1'b1;
          w_wdata     = w_rdata + rocc_mem_resp_bits_data;
          w_state_nxt = r_xd ? S_RESP : S_IDLE;
        end
      end
      S_RESP: if (rocc_resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rocc_cmd_ready      = (r_state == S_IDLE);
  assign rocc_busy           = (r_state != S_IDLE);
  assign rocc_interrupt      = 1'b0;
  assign rocc_resp_valid     = (r_state == S_RESP);
  assign rocc_resp_bits_rd   = r_rd;
  assign rocc_resp_bits_data = is_nop(r_funct) ? '0 : w_rdata;

  assign rocc_mem_req_valid         = (r_state == S_MEM_REQ);
  assign rocc_mem_req_bits_addr     = r_addr;
  assign rocc_mem_req_bits_tag      = '0;
  assign rocc_mem_req_bits_cmd      = MEM_CMD_XRD;
  assign rocc_mem_req_bits_size     = 2'd3;
  assign rocc_mem_req_bits_signed   = 1'b0;
  assign rocc_mem_req_bits_phys     = 1'b0;
  assign rocc_mem_req_bits_no_alloc = 1'b0;
  assign rocc_mem_req_bits_no_xcpt  = 1'b0;
  assign rocc_mem_req_bits_no_resp  = 1'b0;
  assign rocc_mem_req_bits_dv       = 1'b0;
  assign rocc_mem_req_bits_dprv     = r_dprv;

endmodule

// File: tb/tb_rocc_acc_unit.sv
// Bench for rocc_acc_unit: vector table, load corner sequences, randomized ops vs array model.
module tb_rocc_acc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        rocc_cmd_valid, rocc_cmd_ready;
  logic [6:0]  rocc_cmd_bits_inst_funct;
  logic [4:0]  rocc_cmd_bits_inst_rd;
  logic        rocc_cmd_bits_inst_xd;
  logic [63:0] rocc_cmd_bits_rs1, rocc_cmd_bits_rs2;
  logic [1:0]  rocc_cmd_bits_status_dprv;
  logic        rocc_resp_ready, rocc_resp_valid;
  logic [4:0]  rocc_resp_bits_rd;
  logic [63:0] rocc_resp_bits_data;
  logic        rocc_mem_req_ready, rocc_mem_req_valid;
  logic [39:0] rocc_mem_req_bits_addr;
  logic [8:0]  rocc_mem_req_bits_tag;
  logic [4:0]  rocc_mem_req_bits_cmd;
  logic [1:0]  rocc_mem_req_bits_size, rocc_mem_req_bits_dprv;
  logic        rocc_mem_req_bits_signed, rocc_mem_req_bits_phys, rocc_mem_req_bits_no_alloc;
  logic        rocc_mem_req_bits_no_xcpt, rocc_mem_req_bits_no_resp, rocc_mem_req_bits_dv;
  logic        rocc_mem_s2_nack, rocc_mem_resp_valid;
  logic [63:0] rocc_mem_resp_bits_data;
  logic        rocc_busy, rocc_interrupt;

  rocc_acc_unit dut (
    .clock(clock), .reset(reset),
    .rocc_cmd_valid(rocc_cmd_valid), .rocc_cmd_ready(rocc_cmd_ready),
    .rocc_cmd_bits_inst_funct(rocc_cmd_bits_inst_funct), .rocc_cmd_bits_inst_rd(rocc_cmd_bits_inst_rd),
    .rocc_cmd_bits_inst_xd(rocc_cmd_bits_inst_xd), .rocc_cmd_bits_rs1(rocc_cmd_bits_rs1),
    .rocc_cmd_bits_rs2(rocc_cmd_bits_rs2), .rocc_cmd_bits_status_dprv(rocc_cmd_bits_status_dprv),
    .rocc_resp_ready(rocc_resp_ready), .rocc_resp_valid(rocc_resp_valid),
    .rocc_resp_bits_rd(rocc_resp_bits_rd), .rocc_resp_bits_data(rocc_resp_bits_data),
    .rocc_mem_req_ready(rocc_mem_req_ready), .rocc_mem_req_valid(rocc_mem_req_valid),
    .rocc_mem_req_bits_addr(rocc_mem_req_bits_addr), .rocc_mem_req_bits_tag(rocc_mem_req_bits_tag),
    .rocc_mem_req_bits_cmd(rocc_mem_req_bits_cmd), .rocc_mem_req_bits_size(rocc_mem_req_bits_size),
    .rocc_mem_req_bits_signed(rocc_mem_req_bits_signed), .rocc_mem_req_bits_phys(rocc_mem_req_bits_phys),
    .rocc_mem_req_bits_no_alloc(rocc_mem_req_bits_no_alloc), .rocc_mem_req_bits_no_xcpt(rocc_mem_req_bits_no_xcpt),
    .rocc_mem_req_bits_no_resp(rocc_mem_req_bits_no_resp), .rocc_mem_req_bits_dv(rocc_mem_req_bits_dv),
    .rocc_mem_req_bits_dprv(rocc_mem_req_bits_dprv),
    .rocc_mem_s2_nack(rocc_mem_s2_nack), .rocc_mem_resp_valid(rocc_mem_resp_valid),
    .rocc_mem_resp_bits_data(rocc_mem_resp_bits_data),
    .rocc_busy(rocc_busy), .rocc_interrupt(rocc_interrupt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  logic [63:0] acc_m [4];

  always @(posedge clock) if (rocc_mem_req_valid && rocc_mem_req_ready) hs_cnt <= hs_cnt + 1;

  wire [23:0] req_misc = {rocc_mem_req_bits_tag, rocc_mem_req_bits_cmd, rocc_mem_req_bits_size,
                          rocc_mem_req_bits_signed, rocc_mem_req_bits_phys, rocc_mem_req_bits_no_alloc,
                          rocc_mem_req_bits_no_xcpt, rocc_mem_req_bits_no_resp, rocc_mem_req_bits_dv,
                          rocc_mem_req_bits_dprv};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: accumulator array updated with plain arithmetic; returns the response value.
  task automatic model_cmd(input logic [6:0] f, input logic [63:0] rs2, input logic [63:0] rs1,
                           output logic [63:0] exp);
    int i;
    i = int'(rs2[1:0]);
    if (f == 7'd0) acc_m[i] = rs1;
    else if (f == 7'd2) acc_m[i] = acc_m[i] + rs1;
    exp = (f <= 7'd2) ? acc_m[i] : 64'd0;
  endtask

  task automatic cmd(input logic [6:0] f, input logic [63:0] rs2, input logic [63:0] rs1, input bit xd,
                     input logic [4:0] rd, input int stall, input logic [63:0] exp, input string nm);
    @(negedge clock);
    chk({nm, " cmd_ready"}, rocc_cmd_ready, 1);
    rocc_cmd_valid = 1; rocc_cmd_bits_inst_funct = f; rocc_cmd_bits_rs2 = rs2; rocc_cmd_bits_rs1 = rs1;
    rocc_cmd_bits_inst_xd = xd; rocc_cmd_bits_inst_rd = rd;
    rocc_cmd_bits_status_dprv = 2'($urandom_range(0, 3));
    rocc_resp_ready = (stall == 0);
    @(negedge clock);
    rocc_cmd_valid = 0; rocc_cmd_bits_rs1 = {$urandom, $urandom}; rocc_cmd_bits_rs2 = {$urandom, $urandom};
    if (xd) begin
      for (int k = 0; k <= stall; k++) begin
        chk({nm, " resp_valid"}, rocc_resp_valid, 1);
        chk({nm, " resp_data"}, rocc_resp_bits_data, exp);
        chk({nm, " resp_rd"}, rocc_resp_bits_rd, rd);
        if (k < stall) chk({nm, " cmd_ready held low"}, rocc_cmd_ready, 0);
        rocc_resp_ready = (k >= stall);
        @(negedge clock);
      end
    end
    rocc_resp_ready = 1;
    chk({nm, " resp_valid done"}, rocc_resp_valid, 0);
    chk({nm, " busy done"}, rocc_busy, 0);
  endtask

  task automatic load(input logic [63:0] rs2, input logic [63:0] rs1, input bit xd, input logic [4:0] rd,
                      input int dly, input int nacks, input logic [63:0] data, input string nm);
    int i, hs0;
    logic [1:0]  dprv;
    logic [63:0] exp;
    i = int'(rs2[1:0]);
    acc_m[i] = acc_m[i] + data;
    exp = acc_m[i];
    dprv = 2'($urandom_range(0, 3));
    @(negedge clock);
    chk({nm, " cmd_ready"}, rocc_cmd_ready, 1);
    rocc_cmd_valid = 1; rocc_cmd_bits_inst_funct = 7'd3; rocc_cmd_bits_rs2 = rs2; rocc_cmd_bits_rs1 = rs1;
    rocc_cmd_bits_inst_xd = xd; rocc_cmd_bits_inst_rd = rd; rocc_cmd_bits_status_dprv = dprv;
    rocc_mem_req_ready = 0; rocc_resp_ready = 1;
    @(negedge clock);
    rocc_cmd_valid = 0; rocc_cmd_bits_rs1 = {$urandom, $urandom}; rocc_cmd_bits_status_dprv = ~dprv;
    hs0 = hs_cnt;
    for (int a = 0; a <= nacks; a++) begin
      for (int k = 0; k <= dly; k++) begin
        chk({nm, " req_valid"}, rocc_mem_req_valid, 1);
        chk({nm, " req_addr"}, rocc_mem_req_bits_addr, rs1[39:0]);
        chk({nm, " req_fields"}, req_misc, {9'd0, 5'd0, 2'd3, 6'd0, dprv});
        chk({nm, " busy"}, rocc_busy, 1);
        rocc_mem_req_ready = (k == dly);
        @(negedge clock);
      end
      rocc_mem_req_ready = 0;
      chk({nm, " req_valid in wait"}, rocc_mem_req_valid, 0);
      if (a < nacks) rocc_mem_s2_nack = 1;
      else begin rocc_mem_resp_valid = 1; rocc_mem_resp_bits_data = data; end
      @(negedge clock);
      rocc_mem_s2_nack = 0; rocc_mem_resp_valid = 0; rocc_mem_resp_bits_data = {$urandom, $urandom};
    end
    chk({nm, " req handshakes"}, 64'(hs_cnt - hs0), 64'(nacks + 1));
    if (xd) begin
      chk({nm, " resp_valid"}, rocc_resp_valid, 1);
      chk({nm, " resp_data"}, rocc_resp_bits_data, exp);
      chk({nm, " resp_rd"}, rocc_resp_bits_rd, rd);
      @(negedge clock);
    end
    chk({nm, " busy done"}, rocc_busy, 0);
    chk({nm, " resp_valid done"}, rocc_resp_valid, 0);
  endtask

  typedef struct {
    logic [6:0]  f;
    logic [63:0] rs2;
    logic [63:0] rs1;
    bit          xd;
    logic [4:0]  rd;
    int          stall;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [63:0] e;
    tbl[0]  = '{7'd0,   64'd1, 64'd5,  1'b0, 5'd0, 0, 64'd0};
    tbl[1]  = '{7'd1,   64'd1, 64'd0,  1'b1, 5'd7, 0, 64'd5};
    tbl[2]  = '{7'd0,   64'd0, 64'd2,  1'b1, 5'd3, 0, 64'd2};
    tbl[3]  = '{7'd2,   64'd0, '1,     1'b1, 5'd4, 0, 64'd1};
    tbl[4]  = '{7'd1,   64'd1, 64'd0,  1'b1, 5'd9, 4, 64'd5};
    tbl[5]  = '{7'd5,   64'd1, 64'd123,1'b1, 5'd2, 0, 64'd0};
    tbl[6]  = '{7'd127, 64'd1, 64'd99, 1'b0, 5'd0, 0, 64'd0};
    tbl[7]  = '{7'd1,   64'd1, 64'd0,  1'b1, 5'd8, 1, 64'd5};
    tbl[8]  = '{7'd2,   64'd3, 64'd10, 1'b0, 5'd0, 0, 64'd0};
    tbl[9]  = '{7'd2,   64'd3, 64'h20, 1'b1, 5'd31,2, 64'h2a};
    tbl[10] = '{7'd1,   64'd2, 64'd0,  1'b1, 5'd1, 0, 64'd0};
    tbl[11] = '{7'd0,   64'hABCD_0000_0000_0002, 64'h77, 1'b1, 5'd5, 0, 64'h77};

    for (int k = 0; k < 4; k++) acc_m[k] = 64'd0;
    reset = 1; rocc_cmd_valid = 0; rocc_cmd_bits_inst_funct = 0; rocc_cmd_bits_inst_rd = 0;
    rocc_cmd_bits_inst_xd = 0; rocc_cmd_bits_rs1 = 0; rocc_cmd_bits_rs2 = 0; rocc_cmd_bits_status_dprv = 0;
    rocc_resp_ready = 1; rocc_mem_req_ready = 0; rocc_mem_s2_nack = 0; rocc_mem_resp_valid = 0;
    rocc_mem_resp_bits_data = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("reset cmd_ready", rocc_cmd_ready, 1);
    chk("reset busy", rocc_busy, 0);
    chk("reset resp_valid", rocc_resp_valid, 0);
    chk("reset mem_req_valid", rocc_mem_req_valid, 0);
    chk("interrupt", rocc_interrupt, 0);

    for (int k = 0; k < 12; k++) begin
      model_cmd(tbl[k].f, tbl[k].rs2, tbl[k].rs1, e);
      cmd(tbl[k].f, tbl[k].rs2, tbl[k].rs1, tbl[k].xd, tbl[k].rd, tbl[k].stall, tbl[k].exp,
          $sformatf("vec%0d", k));
    end

    // Load with request stalled 3 cycles into a cleared acc2.
    model_cmd(7'd0, 64'd2, 64'd0, e);
    cmd(7'd0, 64'd2, 64'd0, 1'b0, 5'd0, 0, e, "clr acc2");
    load(64'd2, 64'h1000, 1'b1, 5'd6, 3, 0, 64'd9, "load stall");
    // Load with one nack: two requests, one accumulate.
    load(64'd0, 64'h2000, 1'b1, 5'd11, 0, 1, 64'd100, "load nack");
    load(64'd1, 64'hFF_1234_5678, 1'b0, 5'd0, 1, 2, 64'hFFFF_FFFF_FFFF_FFFB, "load wrap");

    for (int n = 0; n < 60; n++) begin
      int sel;
      logic [6:0]  f;
      logic [63:0] rs1, rs2;
      sel = $urandom_range(0, 9);
      rs1 = {$urandom, $urandom};
      rs2 = {$urandom, $urandom};
      if (sel >= 5 && sel <= 7) begin
        load(rs2, rs1, 1'($urandom_range(0, 1)), 5'($urandom), $urandom_range(0, 2),
             $urandom_range(0, 1), {$urandom, $urandom}, $sformatf("rnd%0d load", n));
      end else begin
        f = (sel <= 1) ? 7'd0 : (sel == 2 || sel == 9) ? 7'd1 : (sel <= 4) ? 7'd2 : 7'($urandom_range(4, 127));
        model_cmd(f, rs2, rs1, e);
        cmd(f, rs2, rs1, 1'($urandom_range(0, 1)), 5'($urandom), $urandom_range(0, 2), e,
            $sformatf("rnd%0d f%0d", n, f));
      end
    end

    // Reset while waiting for load data; a late response must not land.
    @(negedge clock);
    rocc_cmd_valid = 1; rocc_cmd_bits_inst_funct = 7'd3; rocc_cmd_bits_rs2 = 64'd1;
    rocc_cmd_bits_rs1 = 64'h3000; rocc_cmd_bits_inst_xd = 1;
    @(negedge clock);
    rocc_cmd_valid = 0; rocc_mem_req_ready = 1;
    @(negedge clock);
    rocc_mem_req_ready = 0;
    chk("rst mid busy", rocc_busy, 1);
    #2 reset = 1;
    #1;
    chk("rst mid req_valid", rocc_mem_req_valid, 0);
    chk("rst mid resp_valid", rocc_resp_valid, 0);
    chk("rst mid busy", rocc_busy, 0);
    chk("rst mid cmd_ready", rocc_cmd_ready, 1);
    @(negedge clock);
    reset = 0;
    for (int k = 0; k < 4; k++) acc_m[k] = 64'd0;
    rocc_mem_resp_valid = 1; rocc_mem_resp_bits_data = 64'd55;
    @(negedge clock);
    rocc_mem_resp_valid = 0;
    chk("rst late resp busy", rocc_busy, 0);
    for (int k = 0; k < 4; k++) begin
      model_cmd(7'd1, 64'(k), 64'd0, e);
      cmd(7'd1, 64'(k), 64'd0, 1'b1, 5'(k), 0, e, $sformatf("post-rst read%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/rocc_acc_unit.md
ROCC_ACC_UNIT -- requirements
Module: rocc_acc_unit

Interface
REQ-001 SHALL have parameter xLen, default 64, datapath and accumulator width.
REQ-002 SHALL have parameter NUM_ACC, default 4, accumulator count; power of two, 2..16.
REQ-003 SHALL have parameter coreMaxAddrBits, default 40, memory address width.
REQ-004 SHALL have parameter dcacheReqTagBits, default 9, memory tag width.
REQ-005 SHALL have ports clock (in, 1, sole clock) and reset (in, 1, asynchronous, active-high).
REQ-006 SHALL have ports rocc_cmd_valid (in, 1), rocc_cmd_ready (out, 1): command handshake.
REQ-007 SHALL have inputs rocc_cmd_bits_inst_funct (7), rocc_cmd_bits_inst_rd (5), rocc_cmd_bits_inst_xd (1), rocc_cmd_bits_rs1 (xLen), rocc_cmd_bits_rs2 (xLen) and rocc_cmd_bits_status_dprv (2): command fields.
REQ-008 SHALL have rocc_resp_ready (in, 1), rocc_resp_valid (out, 1), rocc_resp_bits_rd (out, 5) and rocc_resp_bits_data (out, xLen): response channel.
REQ-009 SHALL have rocc_mem_req_ready (in, 1), rocc_mem_req_valid (out, 1), rocc_mem_req_bits_addr (out, coreMaxAddrBits), _tag (out, dcacheReqTagBits), _cmd (out, 5), _size (out, 2), _signed, _phys, _no_alloc, _no_xcpt, _no_resp, _dv (out, 1 each), and _dprv (out, 2): load request.
REQ-010 SHALL have rocc_mem_s2_nack (in, 1), rocc_mem_resp_valid (in, 1) and rocc_mem_resp_bits_data (in, xLen): load completion.
REQ-011 SHALL have outputs rocc_busy (1) and rocc_interrupt (1).

Function
REQ-012 SHALL decode funct 0 WRITE (acc[i] <= rs1), 1 READ (no change), 2 ACCUM (acc[i] <= acc[i] + rs1), 3 LOAD (acc[i] <= acc[i] + mem[rs1]); i = rs2[log2(NUM_ACC)-1:0].
REQ-013 SHALL treat funct 4..127 as NOP: no accumulator change; response data zero when xd=1.
REQ-014 SHALL add modulo 2^xLen, no saturation or carry-out.
REQ-015 SHALL implement FSM IDLE, MEM_REQ, MEM_WAIT, RESP; rocc_cmd_ready = 1 only in IDLE.
REQ-016 SHALL, on command accepted at cycle T with funct!=LOAD, update the accumulator at T+1; xd=1 -> RESP at T+1, else IDLE at T+1.
REQ-017 SHALL, for LOAD, enter MEM_REQ at T+1 and drive rocc_mem_req_valid with addr=rs1[coreMaxAddrBits-1:0], cmd=5'b00000, size=3, tag=0, dprv=captured status_dprv, all other single-bit request fields 0.
REQ-018 SHALL, on mem_req valid&&ready, move MEM_REQ->MEM_WAIT, holding request fields stable until accepted.
REQ-019 SHALL, on rocc_mem_s2_nack in MEM_WAIT, return to MEM_REQ and reissue the identical request.
REQ-020 SHALL, on rocc_mem_resp_valid in MEM_WAIT, add the data into acc[i] that cycle, then enter RESP if xd=1, else IDLE.
REQ-021 SHALL drive rocc_resp_bits_data = post-operation acc[i] (READ: current value), rd = captured inst_rd, valid held until resp_ready; RESP->IDLE on handshake.
REQ-022 SHALL assert rocc_busy whenever state != IDLE; rocc_interrupt tied 0.
REQ-023 SHALL ignore rocc_mem_resp_valid outside MEM_WAIT.

Reset
REQ-024 SHALL, on reset (including mid-operation), enter IDLE and clear all accumulators and captured fields to 0; mem_req_valid, resp_valid, busy = 0, cmd_ready = 1 after deassertion; any outstanding load response is dropped.

Structure
REQ-025 SHALL place the funct encodings, FSM state enumeration and memory command constant in shared package rocc_acc_pkg.
REQ-026 SHALL contain one sub-module, rocc_acc_regfile (NUM_ACC x xLen, one read port, one write port).

Verification
REQ-027 WRITE acc1=5 then READ acc1 xd=1 rd=7 -> resp_valid at T+1, data 5, rd 7.
REQ-028 ACCUM acc0 rs1=2^64-1 onto acc0=2 -> resp data 1 (wrap).
REQ-029 LOAD rs1=0x1000 idx2, mem_req_ready low 3 cycles, then mem_resp data 9 -> request stable throughout, acc2=9, busy high until resp handshake.
REQ-030 LOAD with one s2_nack -> exactly two request handshakes, same addr, single accumulate.
REQ-031 READ with resp_ready low 4 cycles -> resp_valid/data held, cmd_ready 0 until handshake.
REQ-032 Reset asserted in MEM_WAIT -> outputs to reset values immediately; later mem_resp_valid leaves acc unchanged.
